// File: rtl/zeus_vram_pkg.sv
// -----------------------------------------------------------------------------
// zeus_vram_pkg
//   Shared constants and types for the VRAM port arbitration logic.
//   - VRAM_AW / VRAM_DW / VRAM_BEW : VRAM word address, data and byte-enable widths
//   - REQ_*                        : fixed requester slot assignments
//   - arb_state_t                  : arbiter FSM state encoding
//   - rr_next()                    : round-robin successor, wrapping past slot 0
// -----------------------------------------------------------------------------
package zeus_vram_pkg;

    localparam int VRAM_AW  = 15;
    localparam int VRAM_DW  = 32;
    localparam int VRAM_BEW = 4;

    localparam int REQ_COMPOSITOR = 0;
    localparam int REQ_L0         = 1;
    localparam int REQ_L1         = 2;
    localparam int REQ_CPU        = 3;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    // Slot following 'grant' in the round-robin ring 1..num_req-1.
    // Slot 0 is never part of the ring.
    function automatic int rr_next(input int grant, input int num_req);
        return (grant + 1 >= num_req) ? 1 : grant + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
//   Combinational winner selection for the VRAM arbiter.
//   Slot 0 (compositor) wins whenever its strobe is high; otherwise the first
//   set strobe at or after rr_ptr wins, searching rr_ptr..NUM_REQ-1 then 1..
//   Ports:
//     strobe  in   NUM_REQ   pending request strobes
//     rr_ptr  in   PW        round-robin start slot, always in 1..NUM_REQ-1
//     grant   out  PW        winning slot index (0 when valid is low)
//     valid   out  1         at least one strobe is high
// -----------------------------------------------------------------------------
module rr_priority_picker
    import zeus_vram_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] strobe,
    input  logic [PW-1:0]      rr_ptr,
    output logic [PW-1:0]      grant,
    output logic               valid
);

    // One extra bit so rr_ptr + offset cannot overflow before the wrap.
    localparam logic [PW:0] N_ALL = (PW + 1)'(NUM_REQ);
    localparam logic [PW:0] N_RR  = (PW + 1)'(NUM_REQ - 1);

    logic [PW:0] cand;

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it holding its old value and infer a latch.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        cand  = '0;
        if (strobe[REQ_COMPOSITOR]) begin
            grant = PW'(REQ_COMPOSITOR);
            valid = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                cand = {1'b0, rr_ptr} + (PW + 1)'(k);
                // Wrap from NUM_REQ-1 back to 1, skipping slot 0.
                if (cand >= N_ALL) begin
                    cand = cand - N_RR;
                end
                if (!valid && strobe[cand[PW-1:0]]) begin
                    grant = cand[PW-1:0];
                    valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//   Shares the single 32-bit VRAM port between NUM_REQ strobe/ack requesters.
//   Slot 0 is the real-time compositor palette fetch with fixed top priority;
//   slots 1..NUM_REQ-1 are served round-robin. One transaction in flight.
//   Parameters:
//     NUM_REQ   requester count, 2..8
//     TIMEOUT   BUSY cycles before aborting a transaction; 0 = never abort
//   Ports:
//     clk_i, rst_i              clock, asynchronous active-high reset
//     req_strobe_i/we_i         per-requester request and write flag
//     req_addr_i/wdata_i/be_i   per-requester address, data, byte enables
//     req_ack_o                 one-hot completion pulse
//     req_rdata_o, req_err_o    read data and timeout flag, valid with ack
//     mem_strobe_o/we_o/addr_o/wdata_o/be_o   registered VRAM request
//     mem_ack_i, mem_rdata_i    VRAM completion and read data
// -----------------------------------------------------------------------------
module vram_arbiter
    import zeus_vram_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_strobe_i,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*VRAM_AW-1:0]    req_addr_i,
    input  logic [NUM_REQ*VRAM_DW-1:0]    req_wdata_i,
    input  logic [NUM_REQ*VRAM_BEW-1:0]   req_be_i,
    output logic [NUM_REQ-1:0]            req_ack_o,
    output logic [VRAM_DW-1:0]            req_rdata_o,
    output logic                          req_err_o,
    output logic                          mem_strobe_o,
    output logic                          mem_we_o,
    output logic [VRAM_AW-1:0]            mem_addr_o,
    output logic [VRAM_DW-1:0]            mem_wdata_o,
    output logic [VRAM_BEW-1:0]           mem_be_o,
    input  logic                          mem_ack_i,
    input  logic [VRAM_DW-1:0]            mem_rdata_i
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value at which the final BUSY cycle is running; only meaningful
    // when TIMEOUT is non-zero.
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    arb_state_t           state;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        grant_q;
    logic [PW-1:0]        pick_grant;
    logic                 pick_valid;
    logic [CW-1:0]        tmo_cnt;
    logic                 timeout_hit;
    logic [NUM_REQ-1:0]   grant_onehot;

    assign timeout_hit  = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
    assign grant_onehot = NUM_REQ'(1) << grant_q;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_picker (
        .strobe  (req_strobe_i),
        .rr_ptr  (rr_ptr),
        .grant   (pick_grant),
        .valid   (pick_valid)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // in this block sees the pre-edge values of the others.
    // NOTE: every register, including the data-carrying ones, is reset: the
    // VRAM controller and requesters see clean zeros while rst_i is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ARB_IDLE;
            rr_ptr       <= PW'(1);
            grant_q      <= '0;
            tmo_cnt      <= '0;
            req_ack_o    <= '0;
            req_rdata_o  <= '0;
            req_err_o    <= 1'b0;
            mem_strobe_o <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            mem_be_o     <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant_q      <= pick_grant;
                        mem_strobe_o <= 1'b1;
                        mem_we_o     <= req_we_i[pick_grant];
                        mem_addr_o   <= req_addr_i[int'(pick_grant)*VRAM_AW +: VRAM_AW];
                        mem_wdata_o  <= req_wdata_i[int'(pick_grant)*VRAM_DW +: VRAM_DW];
                        mem_be_o     <= req_be_i[int'(pick_grant)*VRAM_BEW +: VRAM_BEW];
                        tmo_cnt      <= '0;
                        state        <= ARB_BUSY;
                    end
                end

                ARB_BUSY: begin
                    // A memory ack in the timeout cycle still counts as a
                    // normal completion, so it is tested first.
                    if (mem_ack_i) begin
                        mem_strobe_o <= 1'b0;
                        req_rdata_o  <= mem_rdata_i;
                        req_ack_o    <= grant_onehot;
                        req_err_o    <= 1'b0;
                        if (grant_q != PW'(REQ_COMPOSITOR)) begin
                            rr_ptr <= PW'(rr_next(int'(grant_q), NUM_REQ));
                        end
                        state <= ARB_DONE;
                    end else if (timeout_hit) begin
                        // Aborted transactions leave the ring pointer alone;
                        // only a real completion advances it.
                        mem_strobe_o <= 1'b0;
                        req_rdata_o  <= '0;
                        req_ack_o    <= grant_onehot;
                        req_err_o    <= 1'b1;
                        state        <= ARB_DONE;
                    end else if (TIMEOUT != 0) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ARB_DONE: begin
                    // No arbitration here: the acked requester gets this edge
                    // to drop its strobe before IDLE samples again.
                    req_ack_o <= '0;
                    req_err_o <= 1'b0;
                    tmo_cnt   <= '0;
                    state     <= ARB_IDLE;
                end

                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//   Self-checking bench for vram_arbiter (NUM_REQ=4, TIMEOUT=8). Requesters and
//   the VRAM are modelled behaviourally; a transaction-level reference model
//   predicts grants, ack pulses, read data and timeouts cycle by cycle.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

    localparam int NR  = 4;
    localparam int TMO = 8;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [NR-1:0]     req_strobe_i;
    logic [NR-1:0]     req_we_i;
    logic [NR*15-1:0]  req_addr_i;
    logic [NR*32-1:0]  req_wdata_i;
    logic [NR*4-1:0]   req_be_i;
    logic [NR-1:0]     req_ack_o;
    logic [31:0]       req_rdata_o;
    logic              req_err_o;
    logic              mem_strobe_o;
    logic              mem_we_o;
    logic [14:0]       mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic              mem_ack_i = 1'b0;
    logic [31:0]       mem_rdata_i = '0;

    always #5 clk_i = ~clk_i;

    vram_arbiter #(
        .NUM_REQ (NR),
        .TIMEOUT (TMO)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_strobe_i (req_strobe_i),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_be_i     (req_be_i),
        .req_ack_o    (req_ack_o),
        .req_rdata_o  (req_rdata_o),
        .req_err_o    (req_err_o),
        .mem_strobe_o (mem_strobe_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    // Requester records: contents are frozen while a request is pending.
    logic        r_pend  [NR];
    logic        r_we    [NR];
    logic [14:0] r_addr  [NR];
    logic [31:0] r_wdata [NR];
    logic [3:0]  r_be    [NR];

    always_comb begin
        req_strobe_i = '0;
        req_we_i     = '0;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        req_be_i     = '0;
        for (int i = 0; i < NR; i++) begin
            req_strobe_i[i]         = r_pend[i];
            req_we_i[i]             = r_we[i];
            req_addr_i[i*15 +: 15]  = r_addr[i];
            req_wdata_i[i*32 +: 32] = r_wdata[i];
            req_be_i[i*4 +: 4]      = r_be[i];
        end
    end

    // Reference model and bench bookkeeping.
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          m_rr = 1;
    bit          m_busy = 1'b0;
    int          m_grant = 0;
    int          m_bcnt = 0;
    int          m_seen = 0;
    int          m_lat = 1;
    int          free_at = 0;
    int          done_cnt = 0;
    int          force_lat = 1;
    bit          force_rd_en = 1'b0;
    logic [31:0] force_rdata = '0;
    bit          spurious_en = 1'b0;
    bit          withdraw_en = 1'b0;
    bit          rand_issue_en = 1'b0;
    int          reissue_left = 0;
    int          ack_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Winner by the arbitration rules: slot 0 first, then ring order from m_rr.
    function automatic int model_pick(input logic [NR-1:0] stb);
        if (stb[0]) return 0;
        for (int k = 0; k < NR - 1; k++) begin
            int i;
            i = ((m_rr - 1 + k) % (NR - 1)) + 1;
            if (stb[i]) return i;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int log_at(input int k);
        return (k < ack_log.size()) ? ack_log[k] : -1;
    endfunction

    function automatic int rand_lat();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 6)  return 0;
        if (r < 10) return 8;
        if (r < 13) return 9;
        return int'($urandom_range(1, 4));
    endfunction

    task automatic issue(input int i, input logic we, input logic [14:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        r_we[i]    = we;
        r_addr[i]  = a;
        r_wdata[i] = d;
        r_be[i]    = be;
        r_pend[i]  = 1'b1;
    endtask

    task automatic issue_rand(input int i);
        issue(i, 1'($urandom_range(0, 1)), 15'($urandom), $urandom, 4'($urandom_range(1, 15)));
    endtask

    // One clock: advance the model over the edge, compare, then drive the
    // memory and requesters for the next edge.
    task automatic step();
        logic [NR-1:0] stb_e;
        logic          ack_e;
        logic [31:0]   rd_e;
        logic [NR-1:0] exp_ack;
        logic          exp_err;
        logic [31:0]   exp_rd;
        bit            fin;
        bit            fin_ok;

        for (int i = 0; i < NR; i++) stb_e[i] = r_pend[i];
        ack_e   = mem_ack_i;
        rd_e    = mem_rdata_i;
        exp_ack = '0;
        exp_err = 1'b0;
        exp_rd  = '0;
        fin     = 1'b0;
        fin_ok  = 1'b0;

        @(posedge clk_i);
        cyc++;
        #1;

        if (m_busy) begin
            if (ack_e) begin
                fin    = 1'b1;
                fin_ok = 1'b1;
                exp_rd = rd_e;
            end else begin
                m_bcnt++;
                if (m_bcnt == TMO) begin
                    fin     = 1'b1;
                    exp_err = 1'b1;
                end
            end
            if (fin) begin
                exp_ack = NR'(1) << m_grant;
                m_busy  = 1'b0;
                free_at = cyc + 2;
                if (fin_ok && m_grant != 0) m_rr = (m_grant == NR - 1) ? 1 : m_grant + 1;
                r_pend[m_grant] = 1'b0;
                done_cnt++;
            end
        end else if (cyc >= free_at && stb_e != '0) begin
            m_grant = model_pick(stb_e);
            m_busy  = 1'b1;
            m_bcnt  = 0;
            m_seen  = 0;
            m_lat   = (force_lat >= 0) ? force_lat : rand_lat();
        end

        check("mem_strobe", 64'(mem_strobe_o), 64'(m_busy));
        if (m_busy) begin
            check("mem_we",    64'(mem_we_o),    64'(r_we[m_grant]));
            check("mem_addr",  64'(mem_addr_o),  64'(r_addr[m_grant]));
            check("mem_wdata", 64'(mem_wdata_o), 64'(r_wdata[m_grant]));
            check("mem_be",    64'(mem_be_o),    64'(r_be[m_grant]));
        end
        check("req_ack", 64'(req_ack_o), 64'(exp_ack));
        check("req_err", 64'(req_err_o), 64'(exp_err));
        if (exp_ack != '0) check("req_rdata", 64'(req_rdata_o), 64'(exp_rd));
        if (req_ack_o != '0) ack_log.push_back(onehot_idx(req_ack_o));

        // The finished requester may re-raise at once; DONE must shield it.
        if (fin && reissue_left > 0) begin
            reissue_left--;
            issue_rand(m_grant);
        end

        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
        if (m_busy) begin
            m_seen++;
            if (m_seen == m_lat) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = force_rd_en ? force_rdata : $urandom;
            end
            if (withdraw_en && $urandom_range(0, 15) == 0) r_pend[m_grant] = 1'b0;
        end else if (spurious_en && $urandom_range(0, 7) == 0) begin
            mem_ack_i = 1'b1;
        end

        if (rand_issue_en) begin
            for (int i = 0; i < NR; i++) begin
                if (!r_pend[i] && !(m_busy && m_grant == i) &&
                    $urandom_range(0, (i == 0) ? 11 : 4) == 0) begin
                    issue_rand(i);
                end
            end
        end
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(done_cnt >= target), 64'(1));
    endtask

    initial begin
        int exp_order[$];
        int n;

        for (int i = 0; i < NR; i++) begin
            r_pend[i]  = 1'b0;
            r_we[i]    = 1'b0;
            r_addr[i]  = '0;
            r_wdata[i] = '0;
            r_be[i]    = '0;
        end

        // Reset state, asserted asynchronously between edges.
        #2 rst_i = 1'b1;
        #1;
        check("rst_mem_strobe", 64'(mem_strobe_o), 64'(0));
        check("rst_mem_we",     64'(mem_we_o),     64'(0));
        check("rst_mem_addr",   64'(mem_addr_o),   64'(0));
        check("rst_mem_wdata",  64'(mem_wdata_o),  64'(0));
        check("rst_mem_be",     64'(mem_be_o),     64'(0));
        check("rst_req_ack",    64'(req_ack_o),    64'(0));
        check("rst_req_rdata",  64'(req_rdata_o),  64'(0));
        check("rst_req_err",    64'(req_err_o),    64'(0));
        @(posedge clk_i); cyc++;
        @(posedge clk_i); cyc++;
        #1 rst_i = 1'b0;
        free_at = cyc + 1;

        // Single read from req 2, memory answers on the second BUSY cycle.
        ack_log.delete();
        force_lat   = 2;
        force_rd_en = 1'b1;
        force_rdata = 32'hDEAD_BEEF;
        issue(2, 1'b0, 15'h0123, 32'h0, 4'hF);
        run_until(done_cnt + 1, 20, "read_done");
        check("read_ack_idx", 64'(log_at(0)), 64'(2));
        force_rd_en = 1'b0;

        // Write from req 3 at the top address; mem_* held over 3 BUSY cycles.
        force_lat = 3;
        issue(3, 1'b1, 15'h7FFF, 32'h1234_5678, 4'b0011);
        run_until(done_cnt + 1, 20, "write_done");

        // Contention among 1..3 with strobes re-raised immediately.
        ack_log.delete();
        force_lat = 1;
        issue_rand(1);
        issue_rand(2);
        issue_rand(3);
        reissue_left = 3;
        run_until(done_cnt + 6, 100, "contend_done");
        exp_order = '{1, 2, 3, 1, 2, 3};
        foreach (exp_order[k]) check("contend_order", 64'(log_at(k)), 64'(exp_order[k]));

        // Compositor priority; its grant must not move the ring pointer.
        ack_log.delete();
        issue_rand(0);
        issue_rand(1);
        issue_rand(3);
        run_until(done_cnt + 3, 60, "prio_done");
        exp_order = '{0, 1, 3};
        foreach (exp_order[k]) check("prio_order", 64'(log_at(k)), 64'(exp_order[k]));

        // Timeout with a silent memory, then recovery, then ack on the last cycle.
        force_lat = 0;
        issue_rand(1);
        run_until(done_cnt + 1, 40, "tmo_done");
        force_lat = 1;
        issue_rand(2);
        run_until(done_cnt + 1, 20, "after_tmo_done");
        force_lat = TMO;
        issue_rand(3);
        run_until(done_cnt + 1, 40, "ack_at_tmo_done");
        force_lat = TMO - 1;
        issue_rand(1);
        run_until(done_cnt + 1, 40, "ack_before_tmo_done");

        // Randomised traffic: withdrawals, spurious acks, mixed latencies.
        force_lat     = -1;
        spurious_en   = 1'b1;
        withdraw_en   = 1'b1;
        rand_issue_en = 1'b1;
        repeat (3000) step();
        rand_issue_en = 1'b0;
        withdraw_en   = 1'b0;
        n = 0;
        while ((m_busy || r_pend[0] || r_pend[1] || r_pend[2] || r_pend[3]) && n < 600) begin
            step();
            n++;
        end
        check("drain", 64'(m_busy || r_pend[0] || r_pend[1] || r_pend[2] || r_pend[3]), 64'(0));
        spurious_en = 1'b0;
        repeat (3) step();

        // Reset in BUSY: ring pointer is left at 3 first, then must return to 1.
        force_lat = 1;
        issue_rand(2);
        run_until(done_cnt + 1, 20, "pre_rst_done");
        force_lat = 0;
        issue_rand(1);
        n = 0;
        while (!m_busy && n < 10) begin
            step();
            n++;
        end
        check("rst_busy_reached", 64'(m_busy), 64'(1));
        step();
        step();
        #3 rst_i = 1'b1;
        #1;
        check("rst_async_strobe", 64'(mem_strobe_o), 64'(0));
        check("rst_async_ack",    64'(req_ack_o),    64'(0));
        @(posedge clk_i); cyc++;
        #1;
        check("rst_hold_strobe", 64'(mem_strobe_o), 64'(0));
        check("rst_hold_ack",    64'(req_ack_o),    64'(0));
        check("rst_hold_err",    64'(req_err_o),    64'(0));
        rst_i     = 1'b0;
        m_busy    = 1'b0;
        m_rr      = 1;
        free_at   = cyc + 1;
        mem_ack_i = 1'b0;
        for (int i = 0; i < NR; i++) r_pend[i] = 1'b0;

        ack_log.delete();
        force_lat = 1;
        issue_rand(3);
        issue_rand(2);
        run_until(done_cnt + 2, 40, "post_rst_done");
        exp_order = '{2, 3};
        foreach (exp_order[k]) check("post_rst_order", 64'(log_at(k)), 64'(exp_order[k]));
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
